bsg_cover_mc: RTL



---
 rtl/bsg_cover_mc.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/bsg_cover_mc.sv
`default_nettype none
// ============================================================================
// Module   : bsg_cover_mc
// Brief    : Multi-channel coverage tag collector. Deduplicates {channel, tag}
//            keys in a CAM and drains entries as serialized records. Defining
//            BSG_COVER_HIT_COUNT_EN adds saturating per-entry hit counters.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_cover_mc #(
  parameter int width_p     = 16,
  parameter int els_p       = 4,
  parameter int channels_p  = 2,
  parameter int out_width_p = 32,
  parameter int cnt_width_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [channels_p-1:0]            v_i,
  input  logic [channels_p*width_p-1:0]    data_i,
  output logic [channels_p-1:0]            ready_o,
  input  logic                             flush_i,
  output logic                             gate_o,
  output logic [7:0]                       els_o,
  output logic [7:0]                       len_o,
  input  logic                             ready_i,
  output logic                             v_o,
  output logic                             last_o,
  output logic [out_width_p-1:0]           data_o
);

  localparam int lg_ch_lp  = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int lg_els_lp = $clog2(els_p);
`ifdef BSG_COVER_HIT_COUNT_EN
  localparam int cnt_lp = cnt_width_p;
`else
  // Counter width collapses to nothing when hit counting is compiled out.
  localparam int cnt_lp = 0 * cnt_width_p;
`endif
  localparam int rec_width_lp = cnt_lp + lg_ch_lp + width_p;
  localparam int len_lp       = (rec_width_lp + out_width_p - 1) / out_width_p;
  localparam int pad_width_lp = len_lp * out_width_p;
  localparam int lg_len_lp    = (len_lp > 1) ? $clog2(len_lp) : 1;
  localparam logic [lg_len_lp-1:0] c_last_beat = lg_len_lp'(len_lp - 1);
  localparam logic [lg_els_lp-1:0] c_last_el   = lg_els_lp'(els_p - 1);

  typedef enum logic [0:0] {S_FILL = 1'b0, S_DRAIN = 1'b1} state_e;

  state_e                r_state, w_state_nxt;
  logic [els_p-1:0]      r_valid;
  logic [lg_ch_lp-1:0]   r_chan [els_p];
  logic [width_p-1:0]    r_tag  [els_p];
`ifdef BSG_COVER_HIT_COUNT_EN
  logic [cnt_width_p-1:0] r_cnt [els_p];
  logic [lg_els_lp-1:0]   w_hit_id;
`endif
  logic [lg_ch_lp-1:0]   r_ptr;
  logic [lg_len_lp-1:0]  r_beat;

  logic                  w_gnt_v, w_hs, w_hit, w_free_v, w_fill_full;
  logic [lg_ch_lp-1:0]   w_gnt_id;
  int                    w_rr_idx;
  logic [width_p-1:0]    w_key;
  logic [lg_els_lp-1:0]  w_free_id, w_drain_id;
  logic                  w_above, w_rec_last, w_last, w_beat_hs;
  logic [rec_width_lp-1:0] w_rec;
  logic [pad_width_lp-1:0] w_rec_pad;

  // Round-robin grant: descending scan leaves the nearest requester to r_ptr.
  always_comb begin
    w_gnt_v  = 1'b0;
    w_gnt_id = '0;
    w_rr_idx = 0;
    for (int i = channels_p - 1; i >= 0; i--) begin
      w_rr_idx = int'(r_ptr) + i;
      if (w_rr_idx >= channels_p) w_rr_idx = w_rr_idx - channels_p;
      if (v_i[w_rr_idx]) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = lg_ch_lp'(w_rr_idx);
      end
    end
  end

  assign w_hs  = (r_state == S_FILL) && w_gnt_v;
  assign w_key = data_i[int'(w_gnt_id)*width_p +: width_p];

  always_comb begin
    ready_o = '0;
    if (w_hs && !reset_i) ready_o[w_gnt_id] = 1'b1;
  end

  always_comb begin
    w_hit     = 1'b0;
    w_free_v  = 1'b0;
    w_free_id = '0;
`ifdef BSG_COVER_HIT_COUNT_EN
    w_hit_id  = '0;
`endif
    for (int e = els_p - 1; e >= 0; e--) begin
      if (r_valid[e] && (r_chan[e] == w_gnt_id) && (r_tag[e] == w_key)) begin
        w_hit = 1'b1;
`ifdef BSG_COVER_HIT_COUNT_EN
        w_hit_id = lg_els_lp'(e);
`endif
      end
      if (!r_valid[e]) begin
        w_free_v  = 1'b1;
        w_free_id = lg_els_lp'(e);
      end
    end
  end

  assign w_fill_full = w_hs && !w_hit && w_free_v && (w_free_id == c_last_el);

  // Drain side: lowest valid entry and whether anything remains above it.
  always_comb begin
    w_drain_id = '0;
    for (int e = els_p - 1; e >= 0; e--) begin
      if (r_valid[e]) w_drain_id = lg_els_lp'(e);
    end
    w_above = 1'b0;
    for (int e = 0; e < els_p; e++) begin
      if ((e > int'(w_drain_id)) && r_valid[e]) w_above = 1'b1;
    end
  end

`ifdef BSG_COVER_HIT_COUNT_EN
  assign w_rec = {r_cnt[w_drain_id], r_chan[w_drain_id], r_tag[w_drain_id]};
`else
  assign w_rec = {r_chan[w_drain_id], r_tag[w_drain_id]};
`endif
  assign w_rec_pad  = pad_width_lp'(w_rec);
  assign w_rec_last = (r_beat == c_last_beat);
  assign w_last     = w_rec_last && !w_above;

  assign gate_o    = (r_state != S_FILL) && !reset_i;
  assign v_o       = (r_state == S_DRAIN) && !reset_i;
  assign last_o    = v_o && w_last;
  assign data_o    = w_rec_pad[(len_lp - 1 - int'(r_beat))*out_width_p +: out_width_p];
  assign w_beat_hs = v_o && ready_i;
  assign els_o     = 8'(els_p);
  assign len_o     = 8'(len_lp);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_FILL;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_fill_full || (flush_i && ((|r_valid) || w_hs))) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_beat_hs && w_last) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
      for (int e = 0; e < els_p; e++) begin
        r_chan[e] <= '0;
        r_tag[e]  <= '0;
`ifdef BSG_COVER_HIT_COUNT_EN
        r_cnt[e]  <= '0;
`endif
      end
    end else begin
      if (w_hs) begin
        r_ptr <= (int'(w_gnt_id) == channels_p - 1) ? '0 : w_gnt_id + 1'b1;
        if (w_hit) begin
`ifdef BSG_COVER_HIT_COUNT_EN
          if (r_cnt[w_hit_id] != '1) r_cnt[w_hit_id] <= r_cnt[w_hit_id] + 1'b1;
`endif
        end else if (w_free_v) begin
          r_valid[w_free_id] <= 1'b1;
          r_chan[w_free_id]  <= w_gnt_id;
          r_tag[w_free_id]   <= w_key;
`ifdef BSG_COVER_HIT_COUNT_EN
          r_cnt[w_free_id]   <= cnt_width_p'(1);
`endif
        end
      end
      if (w_beat_hs) begin
        if (w_rec_last) begin
          r_beat              <= '0;
          r_valid[w_drain_id] <= 1'b0;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
